// File: rtl/irrigation_zone_scheduler.sv
// Round-robin multi-zone irrigation scheduler: serves dry zones one at a time,
// with a per-second countdown, reservoir-health gating, pause/abort and alarm handling.
module irrigation_zone_scheduler #(
    parameter int unsigned ZONES          = 4,
    parameter int unsigned TICK_DIV       = 50000000,
    parameter int unsigned SPRINKLER_TIME = 1800,
    parameter int unsigned DRIPPER_TIME   = 3600,
    parameter int unsigned TIME_WIDTH     = 12,
    localparam int unsigned ZW            = (ZONES > 1) ? $clog2(ZONES) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ZONES-1:0]      zone_dry,
    input  logic                  low_water_level,
    input  logic                  mid_water_level,
    input  logic                  high_water_level,
    input  logic                  air_humidity,
    input  logic                  low_temperature,
    input  logic                  skip_pulse,
    output logic [ZONES-1:0]      sprinkler_bomb,
    output logic [ZONES-1:0]      dripper_valvule,
    output logic                  water_supply_valvule,
    output logic                  alarm,
    output logic                  conflicting_values,
    output logic                  busy,
    output logic [ZW-1:0]         active_zone,
    output logic [TIME_WIDTH-1:0] remaining,
    output logic                  zone_done
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [ZW-1:0]         r_ptr, w_ptr_nxt;
    logic [ZW-1:0]         r_zone, w_zone_nxt;
    logic [ZW-1:0]         w_sel, w_cand, w_zone_inc;
    logic [PW-1:0]         r_presc, w_presc_nxt;
    logic [TIME_WIDTH-1:0] r_rem, w_rem_nxt;
    logic                  r_mode_spr, w_mode_nxt;
    logic                  r_skip_d;
    logic                  w_skip_edge, w_conflict, w_water_ok, w_spr_now;
    logic                  w_found, w_tick, w_done_nxt, w_busy_nxt;
    logic [ZONES-1:0]      w_onehot, w_sprk_nxt, w_drip_nxt;
    int unsigned           w_idx;

    assign w_conflict  = (high_water_level & ~mid_water_level) | (mid_water_level & ~low_water_level);
    assign w_water_ok  = low_water_level & ~w_conflict;
    assign w_spr_now   = ~air_humidity & ~low_temperature & mid_water_level;
    assign w_skip_edge = skip_pulse & ~r_skip_d;
    assign w_tick      = (r_presc == PW'(TICK_DIV - 1));
    assign w_zone_inc  = (r_zone == ZW'(ZONES - 1)) ? '0 : r_zone + ZW'(1);

    // First dry zone at or above the pointer, wrapping at ZONES.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        w_idx   = 0;
        for (int unsigned i = 0; i < ZONES; i++) begin
            w_idx = 32'(r_ptr) + i;
            if (w_idx >= ZONES) w_idx = w_idx - ZONES;
            w_cand = ZW'(w_idx);
            if (!w_found && zone_dry[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    // State register plus registered datapath and outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state              <= S_IDLE;
            r_ptr                <= '0;
            r_zone               <= '0;
            r_presc              <= '0;
            r_rem                <= '0;
            r_mode_spr           <= 1'b0;
            r_skip_d             <= 1'b0;
            sprinkler_bomb       <= '0;
            dripper_valvule      <= '0;
            water_supply_valvule <= 1'b0;
            alarm                <= 1'b0;
            conflicting_values   <= 1'b0;
            busy                 <= 1'b0;
            zone_done            <= 1'b0;
        end else begin
            r_state              <= w_state_nxt;
            r_ptr                <= w_ptr_nxt;
            r_zone               <= w_zone_nxt;
            r_presc              <= w_presc_nxt;
            r_rem                <= w_rem_nxt;
            r_mode_spr           <= w_mode_nxt;
            r_skip_d             <= skip_pulse;
            sprinkler_bomb       <= w_sprk_nxt;
            dripper_valvule      <= w_drip_nxt;
            water_supply_valvule <= ~w_conflict & ~high_water_level;
            alarm                <= w_conflict | ~mid_water_level;
            conflicting_values   <= w_conflict;
            busy                 <= w_busy_nxt;
            zone_done            <= w_done_nxt;
        end
    end

    // Next state; abort priority is conflict > skip > dry drop > low water > tick.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_zone_nxt  = r_zone;
        w_presc_nxt = r_presc;
        w_rem_nxt   = r_rem;
        w_mode_nxt  = r_mode_spr;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_conflict) begin
                    w_state_nxt = S_ERROR;
                end else if (w_water_ok && w_found) begin
                    w_state_nxt = S_RUN;
                    w_zone_nxt  = w_sel;
                    w_mode_nxt  = w_spr_now;
                    w_presc_nxt = '0;
                    w_rem_nxt   = w_spr_now ? TIME_WIDTH'(SPRINKLER_TIME) : TIME_WIDTH'(DRIPPER_TIME);
                end
            end
            S_RUN, S_PAUSE: begin
                if (w_conflict) begin
                    w_state_nxt = S_ERROR;
                    w_ptr_nxt   = w_zone_inc;
                    w_rem_nxt   = '0;
                    w_presc_nxt = '0;
                end else if (w_skip_edge || !zone_dry[r_zone]) begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = w_zone_inc;
                    w_rem_nxt   = '0;
                    w_presc_nxt = '0;
                end else if (!low_water_level) begin
                    w_state_nxt = S_PAUSE;
                end else if (r_state == S_PAUSE) begin
                    w_state_nxt = S_RUN;
                end else if (w_tick) begin
                    w_presc_nxt = '0;
                    if (r_rem == TIME_WIDTH'(1)) begin
                        w_state_nxt = S_IDLE;
                        w_ptr_nxt   = w_zone_inc;
                        w_rem_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_rem_nxt   = r_rem - TIME_WIDTH'(1);
                    end
                end else begin
                    w_presc_nxt = r_presc + PW'(1);
                end
            end
            default: begin
                if (!w_conflict) w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the valve register lines up with it.
    always_comb begin
        w_onehot   = ZONES'(1) << w_zone_nxt;
        w_sprk_nxt = '0;
        w_drip_nxt = '0;
        w_busy_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_PAUSE);
        if (w_state_nxt == S_RUN) begin
            if (w_mode_nxt) w_sprk_nxt = w_onehot;
            else            w_drip_nxt = w_onehot;
        end
    end

    assign active_zone = r_zone;
    assign remaining   = r_rem;

endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Directed bench for irrigation_zone_scheduler with ZONES=4, TICK_DIV=4,
// SPRINKLER_TIME=3, DRIPPER_TIME=5; expectations are hand-computed.
module tb_irrigation_zone_scheduler;

    logic        clock;
    logic        reset;
    logic [3:0]  zone_dry;
    logic        low_water_level, mid_water_level, high_water_level;
    logic        air_humidity, low_temperature, skip_pulse;
    logic [3:0]  sprinkler_bomb, dripper_valvule;
    logic        water_supply_valvule, alarm, conflicting_values, busy, zone_done;
    logic [1:0]  active_zone;
    logic [11:0] remaining;

    int n_tests = 0;
    int n_fail  = 0;

    irrigation_zone_scheduler #(
        .ZONES(4), .TICK_DIV(4), .SPRINKLER_TIME(3), .DRIPPER_TIME(5), .TIME_WIDTH(12)
    ) dut (
        .clock(clock), .reset(reset), .zone_dry(zone_dry),
        .low_water_level(low_water_level), .mid_water_level(mid_water_level),
        .high_water_level(high_water_level), .air_humidity(air_humidity),
        .low_temperature(low_temperature), .skip_pulse(skip_pulse),
        .sprinkler_bomb(sprinkler_bomb), .dripper_valvule(dripper_valvule),
        .water_supply_valvule(water_supply_valvule), .alarm(alarm),
        .conflicting_values(conflicting_values), .busy(busy),
        .active_zone(active_zone), .remaining(remaining), .zone_done(zone_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Counts consecutive cycles with any valve open, bounded.
    task automatic run_len(input string tag, input int exp_cycles);
        int cnt = 0;
        while ((sprinkler_bomb != 4'b0 || dripper_valvule != 4'b0) && cnt < 200) begin
            cnt++;
            step(1);
        end
        chk(tag, 32'(cnt), 32'(exp_cycles));
    endtask

    initial begin
        reset = 1'b1; zone_dry = 4'b0;
        low_water_level = 1'b1; mid_water_level = 1'b1; high_water_level = 1'b1;
        air_humidity = 1'b0; low_temperature = 1'b0; skip_pulse = 1'b0;
        step(2);
        chk("rst_sprk", 32'(sprinkler_bomb), 32'(0));
        chk("rst_drip", 32'(dripper_valvule), 32'(0));
        chk("rst_alarm", 32'(alarm), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_rem", 32'(remaining), 32'(0));
        chk("rst_zone", 32'(active_zone), 32'(0));
        reset = 1'b0;
        step(1);
        chk("idle_busy", 32'(busy), 32'(0));
        chk("idle_supply", 32'(water_supply_valvule), 32'(0));

        // Single zone, sprinkler mode
        zone_dry = 4'b0100;
        step(1);
        chk("t1_zone", 32'(active_zone), 32'(2));
        chk("t1_drip", 32'(dripper_valvule), 32'(0));
        chk("t1_busy", 32'(busy), 32'(1));
        for (int i = 0; i < 12; i++) begin
            chk("t1_valve", 32'(sprinkler_bomb), 32'(4'b0100));
            chk("t1_rem", 32'(remaining), 32'(3 - i / 4));
            step(1);
        end
        chk("t1_off", 32'(sprinkler_bomb), 32'(0));
        chk("t1_done", 32'(zone_done), 32'(1));
        chk("t1_rem0", 32'(remaining), 32'(0));
        zone_dry = 4'b1100;
        step(1);
        chk("t1_ptr3", 32'(active_zone), 32'(3));
        chk("t1_sprk3", 32'(sprinkler_bomb), 32'(4'b1000));
        chk("t1_done1", 32'(zone_done), 32'(0));
        zone_dry = 4'b0000;
        step(1);
        chk("t1_drop", 32'(sprinkler_bomb), 32'(0));
        chk("t1_drop_done", 32'(zone_done), 32'(0));

        // Round robin, dripper mode
        zone_dry = 4'b1011; air_humidity = 1'b1;
        step(1);
        chk("rr_z0", 32'(active_zone), 32'(0));
        chk("rr_d0", 32'(dripper_valvule), 32'(4'b0001));
        chk("rr_s0", 32'(sprinkler_bomb), 32'(0));
        chk("rr_rem", 32'(remaining), 32'(5));
        run_len("rr_len0", 20);
        chk("rr_done0", 32'(zone_done), 32'(1));
        step(1);
        chk("rr_z1", 32'(active_zone), 32'(1));
        chk("rr_d1", 32'(dripper_valvule), 32'(4'b0010));
        run_len("rr_len1", 20);
        step(1);
        chk("rr_z3", 32'(active_zone), 32'(3));
        chk("rr_d3", 32'(dripper_valvule), 32'(4'b1000));
        run_len("rr_len3", 20);
        step(1);
        chk("rr_z0b", 32'(active_zone), 32'(0));
        chk("rr_d0b", 32'(dripper_valvule), 32'(4'b0001));
        zone_dry = 4'b0000;
        step(1);
        chk("rr_stop", 32'(busy), 32'(0));

        // Pause and resume on zone 1
        air_humidity = 1'b0; zone_dry = 4'b0010;
        step(1);
        chk("p_zone", 32'(active_zone), 32'(1));
        step(5);
        chk("p_rem2", 32'(remaining), 32'(2));
        low_water_level = 1'b0; mid_water_level = 1'b0; high_water_level = 1'b0;
        step(1);
        chk("p_valve", 32'(sprinkler_bomb), 32'(0));
        chk("p_busy", 32'(busy), 32'(1));
        chk("p_alarm", 32'(alarm), 32'(1));
        chk("p_supply", 32'(water_supply_valvule), 32'(1));
        chk("p_conf", 32'(conflicting_values), 32'(0));
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("p_hold_valve", 32'(sprinkler_bomb), 32'(0));
            chk("p_hold_rem", 32'(remaining), 32'(2));
        end
        low_water_level = 1'b1; mid_water_level = 1'b1; high_water_level = 1'b1;
        step(1);
        chk("p_resume", 32'(sprinkler_bomb), 32'(4'b0010));
        chk("p_resume_rem", 32'(remaining), 32'(2));
        chk("p_alarm_clr", 32'(alarm), 32'(0));
        run_len("p_len", 7);
        chk("p_done", 32'(zone_done), 32'(1));

        // Conflict during RUN of zone 2
        zone_dry = 4'b0101;
        step(1);
        chk("c_zone", 32'(active_zone), 32'(2));
        chk("c_sprk", 32'(sprinkler_bomb), 32'(4'b0100));
        step(2);
        high_water_level = 1'b1; mid_water_level = 1'b0;
        step(1);
        chk("c_valve", 32'(sprinkler_bomb), 32'(0));
        chk("c_flag", 32'(conflicting_values), 32'(1));
        chk("c_alarm", 32'(alarm), 32'(1));
        chk("c_busy", 32'(busy), 32'(0));
        chk("c_supply", 32'(water_supply_valvule), 32'(0));
        step(2);
        chk("c_hold", 32'(conflicting_values), 32'(1));
        mid_water_level = 1'b1;
        step(1);
        chk("c_idle_flag", 32'(conflicting_values), 32'(0));
        chk("c_idle_valve", 32'(sprinkler_bomb), 32'(0));
        step(1);
        chk("c_next_zone", 32'(active_zone), 32'(0));
        chk("c_next_sprk", 32'(sprinkler_bomb), 32'(4'b0001));

        // Skip edge held five cycles, then dry drop
        skip_pulse = 1'b1;
        step(1);
        chk("s_valve", 32'(sprinkler_bomb), 32'(0));
        chk("s_done", 32'(zone_done), 32'(0));
        step(1);
        chk("s_zone2", 32'(active_zone), 32'(2));
        step(3);
        chk("s_once", 32'(sprinkler_bomb), 32'(4'b0100));
        chk("s_rem", 32'(remaining), 32'(3));
        skip_pulse = 1'b0; zone_dry = 4'b0001;
        step(1);
        chk("d_valve", 32'(sprinkler_bomb), 32'(0));
        chk("d_done", 32'(zone_done), 32'(0));
        chk("d_busy", 32'(busy), 32'(0));
        step(1);
        chk("d_next", 32'(sprinkler_bomb), 32'(4'b0001));

        // Asynchronous reset mid-run
        step(2);
        reset = 1'b1;
        #2;
        chk("ar_sprk", 32'(sprinkler_bomb), 32'(0));
        chk("ar_busy", 32'(busy), 32'(0));
        chk("ar_rem", 32'(remaining), 32'(0));
        chk("ar_zone", 32'(active_zone), 32'(0));
        step(2);
        reset = 1'b0; zone_dry = 4'b1111; air_humidity = 1'b1;
        step(1);
        chk("ar_first", 32'(dripper_valvule), 32'(4'b0001));
        chk("ar_first_rem", 32'(remaining), 32'(5));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
